// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions.
//   fetch_state_t    - fetch FSM states (FETCH, REDIRECT_WAIT)
//   RESET_PC_DEFAULT - PC value loaded by reset unless overridden
package pipe_pkg;

  typedef enum logic [0:0] {
    FETCH         = 1'b0,
    REDIRECT_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage : pipe_pkg

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational control-transfer target selection.
// Ports:
//   jump_reg, jump, branch_taken - stage-2 control-transfer kinds
//   jr_target                    - forwarded register value for jr/jalr
//   pc_plus4_s2, instr_s2        - stage-2 PC+4 and instruction word
//   sign_ext_imm                 - sign-extended branch offset, in words
//   target                       - selected target (jump_reg > jump > branch)
// All arithmetic wraps modulo 2^NUM_BITS.
module next_pc_sel
  import pipe_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                jump_reg,
  input  logic                jump,
  input  logic                branch_taken,
  input  logic [NUM_BITS-1:0] jr_target,
  input  logic [NUM_BITS-1:0] pc_plus4_s2,
  input  logic [NUM_BITS-1:0] instr_s2,
  input  logic [NUM_BITS-1:0] sign_ext_imm,
  output logic [NUM_BITS-1:0] target
);

  logic [NUM_BITS-1:0] jr_addr;
  logic [NUM_BITS-1:0] jump_addr;
  logic [NUM_BITS-1:0] branch_addr;

  // Low two bits of jr_target and the opcode field of instr_s2 never
  // contribute to an address.
  logic unused_bits;
  assign unused_bits = ^{jr_target[1:0], instr_s2[NUM_BITS-1:26], branch_taken};

  assign jr_addr     = {jr_target[NUM_BITS-1:2], 2'b00};
  // Shift first, then add: the carry out of the top bit is dropped, which
  // gives the wraparound behaviour the pipeline expects.
  assign branch_addr = pc_plus4_s2 + (sign_ext_imm << 2);

  // Jump keeps the upper region bits of PC+4 and replaces the low 28 bits.
  always_comb begin
    jump_addr        = pc_plus4_s2;
    jump_addr[27:0]  = {instr_s2[25:0], 2'b00};
  end

  always_comb begin
    if (jump_reg)  target = jr_addr;
    else if (jump) target = jump_addr;
    else           target = branch_addr;
  end

endmodule : next_pc_sel

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage with stage-2 pipeline register.
// Ports:
//   clk, rst_n         - clock; synchronous active-low reset
//   stall              - freezes PC, stage-2 registers and FSM
//   imem_addr          - instruction-memory address (the PC register)
//   imem_ready/rdata   - fetch handshake and fetched instruction
//   branch_eq/ne, equal/not_equal, jump, jump_reg, sign_ext_imm, jr_target
//                      - stage-2 control-transfer information
//   instr_s2, pc_plus4_s2, valid_s2 - stage-2 registers
//   redirect_s2        - a taken control transfer is accepted this cycle
// A redirect squashes the instruction fetched in the same cycle. If memory
// is not ready at redirect time, the target is parked in pending_target and
// the in-flight wrong-path fetch is drained in REDIRECT_WAIT.
module pc_fetch
  import pipe_pkg::*;
#(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RESET_PC = NUM_BITS'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  output logic [NUM_BITS-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [NUM_BITS-1:0] imem_rdata,
  input  logic                branch_eq,
  input  logic                branch_ne,
  input  logic                equal,
  input  logic                not_equal,
  input  logic                jump,
  input  logic                jump_reg,
  input  logic [NUM_BITS-1:0] sign_ext_imm,
  input  logic [NUM_BITS-1:0] jr_target,
  output logic [NUM_BITS-1:0] instr_s2,
  output logic [NUM_BITS-1:0] pc_plus4_s2,
  output logic                valid_s2,
  output logic                redirect_s2
);

  fetch_state_t        state_q, state_d;
  logic [NUM_BITS-1:0] pc_q, pc_d;
  logic [NUM_BITS-1:0] instr_s2_q, instr_s2_d;
  logic [NUM_BITS-1:0] pc_plus4_s2_q, pc_plus4_s2_d;
  logic                valid_s2_q, valid_s2_d;
  logic [NUM_BITS-1:0] pending_target_q, pending_target_d;

  logic                branch_taken;
  logic [NUM_BITS-1:0] target;
  logic [NUM_BITS-1:0] pc_plus4;

  assign branch_taken = (branch_eq & equal) | (branch_ne & not_equal);
  // Gated by valid_s2, so bubbles (including every cycle of REDIRECT_WAIT
  // and the cycles following reset) can never raise a redirect.
  assign redirect_s2  = valid_s2_q & ~stall & (jump_reg | jump | branch_taken);
  assign pc_plus4     = pc_q + NUM_BITS'(4);

  next_pc_sel #(
    .NUM_BITS (NUM_BITS)
  ) u_next_pc_sel (
    .jump_reg     (jump_reg),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .pc_plus4_s2  (pc_plus4_s2_q),
    .instr_s2     (instr_s2_q),
    .sign_ext_imm (sign_ext_imm),
    .target       (target)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d          = state_q;
    pc_d             = pc_q;
    instr_s2_d       = instr_s2_q;
    pc_plus4_s2_d    = pc_plus4_s2_q;
    valid_s2_d       = valid_s2_q;
    pending_target_d = pending_target_q;

    if (!stall) begin
      unique case (state_q)
        FETCH: begin
          valid_s2_d = 1'b0;
          if (redirect_s2) begin
            if (imem_ready) begin
              pc_d = target;
            end else begin
              pending_target_d = target;
              state_d          = REDIRECT_WAIT;
            end
          end else if (imem_ready) begin
            instr_s2_d    = imem_rdata;
            pc_plus4_s2_d = pc_plus4;
            pc_d          = pc_plus4;
            valid_s2_d    = 1'b1;
          end
        end
        REDIRECT_WAIT: begin
          valid_s2_d = 1'b0;
          // The data returning now belongs to the wrong path; drop it.
          if (imem_ready) begin
            pc_d    = pending_target_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= FETCH;
      pc_q             <= RESET_PC;
      instr_s2_q       <= '0;
      pc_plus4_s2_q    <= '0;
      valid_s2_q       <= 1'b0;
      pending_target_q <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      instr_s2_q       <= instr_s2_d;
      pc_plus4_s2_q    <= pc_plus4_s2_d;
      valid_s2_q       <= valid_s2_d;
      pending_target_q <= pending_target_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_s2    = instr_s2_q;
  assign pc_plus4_s2 = pc_plus4_s2_q;
  assign valid_s2    = valid_s2_q;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch. A behavioural model of the
// fetch stage tracks PC, stage-2 contents and the wait-for-memory condition;
// every cycle the DUT outputs are compared against it. A table of
// control-transfer vectors and hand-written sequences add fixed-value checks.
module tb_pc_fetch;
  import pipe_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ready;
  logic [31:0] imem_rdata, sign_ext_imm, jr_target;
  logic        branch_eq, branch_ne, equal, not_equal, jump, jump_reg;
  logic [31:0] imem_addr, instr_s2, pc_plus4_s2;
  logic        valid_s2, redirect_s2;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .branch_eq    (branch_eq),
    .branch_ne    (branch_ne),
    .equal        (equal),
    .not_equal    (not_equal),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .sign_ext_imm (sign_ext_imm),
    .jr_target    (jr_target),
    .instr_s2     (instr_s2),
    .pc_plus4_s2  (pc_plus4_s2),
    .valid_s2     (valid_s2),
    .redirect_s2  (redirect_s2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pp4, m_pend;
  bit          m_valid, m_waiting;

  function automatic bit m_redirect();
    bit taken;
    taken = (branch_eq && equal) || (branch_ne && not_equal);
    return m_valid && !stall && (jump_reg || jump || taken);
  endfunction

  function automatic logic [31:0] m_target();
    if (jump_reg) return jr_target & 32'hFFFF_FFFC;
    if (jump)     return (m_pp4 & 32'hF000_0000) | ({6'd0, m_instr[25:0]} * 32'd4);
    return m_pp4 + sign_ext_imm * 32'd4;
  endfunction

  task automatic model_edge();
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc = RST_PC; m_instr = '0; m_pp4 = '0; m_pend = '0;
      m_valid = 0; m_waiting = 0;
    end else if (!stall) begin
      if (m_waiting) begin
        if (imem_ready) begin m_pc = m_pend; m_waiting = 0; end
        m_valid = 0;
      end else if (m_redirect()) begin
        tgt = m_target();
        if (imem_ready) m_pc = tgt;
        else begin m_pend = tgt; m_waiting = 1; end
        m_valid = 0;
      end else if (imem_ready) begin
        m_instr = imem_rdata;
        m_pp4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // Called at edge+1 with inputs already set: compare, clock, advance model.
  task automatic do_cycle();
    #2;
    check("imem_addr",   imem_addr,   m_pc);
    check("valid_s2",    {31'd0, valid_s2}, {31'd0, m_valid});
    check("redirect_s2", {31'd0, redirect_s2}, {31'd0, m_redirect()});
    check("state_wait",  {31'd0, dut.state_q == REDIRECT_WAIT}, {31'd0, m_waiting});
    if (m_valid) begin
      check("instr_s2",    instr_s2,    m_instr);
      check("pc_plus4_s2", pc_plus4_s2, m_pp4);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; branch_eq = 0; branch_ne = 0; equal = 0; not_equal = 0;
    jump = 0; jump_reg = 0; sign_ext_imm = '0; jr_target = '0;
  endtask

  task automatic do_reset();
    rst_n = 0; do_cycle(); rst_n = 1;
  endtask

  // ---------------- control-transfer vectors ----------------
  // Each vector: reset, fetch one instruction (pc_plus4_s2 = 0x00400004),
  // then apply the controls with imem_ready=1.
  typedef struct {
    string       name;
    bit          beq, bne, eq, ne, j, jr;
    logic [31:0] imm, jrt, instr;
    bit          exp_redirect;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"beq_back",   1,0,1,0,0,0, 32'hFFFF_FFFF, 32'h0, 32'h1111_1111, 1, 32'h0040_0000};
    vecs[1] = '{"beq_nottkn", 1,0,0,1,0,0, 32'h0000_0010, 32'h0, 32'h2222_2222, 0, 32'h0040_0008};
    vecs[2] = '{"bne_fwd",    0,1,0,1,0,0, 32'h0000_0010, 32'h0, 32'h3333_3333, 1, 32'h0040_0044};
    vecs[3] = '{"jump_vs_br", 1,0,1,0,1,0, 32'h0000_0100, 32'h0, 32'h0800_0010, 1, 32'h0000_0040};
    vecs[4] = '{"jr_vs_jump", 0,0,0,0,1,1, 32'h0,         32'h0040_0023, 32'h0800_0010, 1, 32'h0040_0020};
    vecs[5] = '{"bne_nottkn", 0,1,1,0,0,0, 32'h0000_0010, 32'h0, 32'h4444_4444, 0, 32'h0040_0008};
    vecs[6] = '{"jr_top",     0,0,0,0,0,1, 32'h0,         32'hFFFF_FFFF, 32'h5555_5555, 1, 32'hFFFF_FFFC};
    vecs[7] = '{"beq_wrap",   1,0,1,0,0,0, 32'h3FFF_FFFF, 32'h0, 32'h6666_6666, 1, 32'h0040_0000};
  end

  initial begin
    clear_ctl();
    rst_n = 0; imem_ready = 0; imem_rdata = '0;
    // First edge establishes a known state in both DUT and model.
    @(posedge clk); model_edge(); #1;

    // Reset with stall, redirect controls and ready all active.
    stall = 1; jump = 1; imem_ready = 1;
    do_cycle();
    #1 check("rst_redirect", {31'd0, redirect_s2}, 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    clear_ctl();
    rst_n = 1;

    // Sequential fetch after reset.
    imem_ready = 1; imem_rdata = 32'hAAAA_0001;
    check("seq0_addr", imem_addr, 32'h0040_0000);
    check("seq0_valid", {31'd0, valid_s2}, 32'd0);
    do_cycle();
    check("seq1_addr", imem_addr, 32'h0040_0004);
    check("seq1_valid", {31'd0, valid_s2}, 32'd1);
    imem_rdata = 32'hAAAA_0002;
    do_cycle();
    check("seq2_addr", imem_addr, 32'h0040_0008);
    check("seq2_pp4", pc_plus4_s2, 32'h0040_0008);

    // beq backwards from pc_plus4_s2=0x00400008.
    branch_eq = 1; equal = 1; sign_ext_imm = 32'hFFFF_FFFE;
    #1 check("beq_redirect", {31'd0, redirect_s2}, 32'd1);
    do_cycle();
    check("beq_addr", imem_addr, 32'h0040_0000);
    check("beq_bubble", {31'd0, valid_s2}, 32'd0);
    clear_ctl();
    do_cycle();
    check("beq_refill", {31'd0, valid_s2}, 32'd1);

    // jr while memory is not ready for two cycles.
    jump_reg = 1; jr_target = 32'h0040_0023; imem_ready = 0;
    do_cycle();
    check("jr_wait_state", {31'd0, dut.state_q == REDIRECT_WAIT}, 32'd1);
    do_cycle();
    check("jr_wait_valid", {31'd0, valid_s2}, 32'd0);
    check("jr_wait_redir", {31'd0, redirect_s2}, 32'd0);
    imem_ready = 1;
    do_cycle();
    check("jr_addr", imem_addr, 32'h0040_0020);
    check("jr_valid", {31'd0, valid_s2}, 32'd0);
    clear_ctl();
    do_cycle();

    // Stall for three cycles on a taken bne.
    branch_ne = 1; not_equal = 1; sign_ext_imm = 32'd4; stall = 1;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      check("stall_addr", imem_addr, 32'h0040_0024);
      check("stall_valid", {31'd0, valid_s2}, 32'd1);
    end
    stall = 0;
    #1 check("stall_release_redir", {31'd0, redirect_s2}, 32'd1);
    do_cycle();
    check("bne_addr", imem_addr, 32'h0040_0034);
    clear_ctl();
    do_cycle();

    // Reset in the middle of REDIRECT_WAIT.
    jump_reg = 1; jr_target = 32'h1234_5678; imem_ready = 0;
    do_cycle();
    check("rw_entered", {31'd0, dut.state_q == REDIRECT_WAIT}, 32'd1);
    clear_ctl();
    rst_n = 0; imem_ready = 1;
    do_cycle();
    check("rw_rst_addr", imem_addr, RST_PC);
    check("rw_rst_state", {31'd0, dut.state_q == REDIRECT_WAIT}, 32'd0);
    rst_n = 1;
    do_cycle();
    do_cycle();
    check("rw_no_pending", imem_addr, 32'h0040_0008);

    // Address wrap: jr to the top word, then fetch from it.
    jump_reg = 1; jr_target = 32'hFFFF_FFFC;
    do_cycle();
    clear_ctl();
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    do_cycle();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_pp4", pc_plus4_s2, 32'h0000_0000);

    // Table of control-transfer vectors.
    foreach (vecs[k]) begin
      clear_ctl();
      do_reset();
      imem_ready = 1; imem_rdata = vecs[k].instr;
      do_cycle();
      branch_eq = vecs[k].beq; branch_ne = vecs[k].bne;
      equal = vecs[k].eq; not_equal = vecs[k].ne;
      jump = vecs[k].j; jump_reg = vecs[k].jr;
      sign_ext_imm = vecs[k].imm; jr_target = vecs[k].jrt;
      #1 check({vecs[k].name, "_redir"}, {31'd0, redirect_s2}, {31'd0, vecs[k].exp_redirect});
      do_cycle();
      check({vecs[k].name, "_addr"}, imem_addr, vecs[k].exp_addr);
    end

    // Randomised traffic against the model.
    clear_ctl();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 99) >= 2);
      stall        = ($urandom_range(0, 3) == 0);
      imem_ready   = ($urandom_range(0, 9) < 7);
      imem_rdata   = $urandom;
      branch_eq    = ($urandom_range(0, 5) == 0);
      branch_ne    = ($urandom_range(0, 5) == 0);
      equal        = $urandom_range(0, 1);
      not_equal    = $urandom_range(0, 1);
      jump         = ($urandom_range(0, 9) == 0);
      jump_reg     = ($urandom_range(0, 11) == 0);
      sign_ext_imm = $urandom;
      jr_target    = $urandom;
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_fetch

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter NUM_BITS, default 32: data and address width.
REQ-002 Parameter RESET_PC, default 32'h0040_0000: PC value after reset.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port stall, input, 1: hazard hold; freezes PC, stage-2 registers and FSM.
REQ-006 Port imem_addr, output, NUM_BITS: instruction-memory address, equal to the PC register.
REQ-007 Port imem_ready, input, 1: the instruction at imem_addr is valid on imem_rdata this cycle.
REQ-008 Port imem_rdata, input, NUM_BITS: fetched instruction.
REQ-009 Ports branch_eq and branch_ne, input, 1 each: stage-2 instruction is beq or bne.
REQ-010 Ports equal and not_equal, input, 1 each: stage-2 comparator results.
REQ-011 Ports jump and jump_reg, input, 1 each: stage-2 instruction is j/jal or jr/jalr.
REQ-012 Port sign_ext_imm, input, NUM_BITS: stage-2 sign-extended branch offset, in words.
REQ-013 Port jr_target, input, NUM_BITS: forwarded register value for jr/jalr.
REQ-014 Ports instr_s2 and pc_plus4_s2, output, NUM_BITS each: registered instruction and PC+4 of stage 2.
REQ-015 Port valid_s2, output, 1: instr_s2 is a real instruction; 0 means bubble.
REQ-016 Port redirect_s2, output, 1: combinational; a taken control transfer was accepted this cycle.

Function
REQ-017 branch_taken SHALL equal (branch_eq & equal) | (branch_ne & not_equal).
REQ-018 redirect_s2 SHALL equal valid_s2 & ~stall & (jump_reg | jump | branch_taken).
REQ-019 Target priority SHALL be jump_reg, then jump, then branch.
- jump_reg: {jr_target[31:2], 2'b00}
- jump: {pc_plus4_s2[31:28], instr_s2[25:0], 2'b00}
- branch: pc_plus4_s2 + (sign_ext_imm << 2)
REQ-020 All address arithmetic SHALL be modulo 2^NUM_BITS; 32'hFFFF_FFFC + 4 = 0.
REQ-021 No branch delay slot: the instruction fetched in the redirect cycle SHALL be squashed (valid_s2 <= 0).
REQ-022 The FSM SHALL have two states, FETCH and REDIRECT_WAIT, plus a NUM_BITS pending_target register.
REQ-023 When stall=1, pc, instr_s2, pc_plus4_s2, valid_s2, state and pending_target SHALL hold. A fetch completing in that cycle is discarded and refetched later.
REQ-024 FETCH, redirect_s2=1, imem_ready=1: pc <= target; valid_s2 <= 0.
REQ-025 FETCH, redirect_s2=1, imem_ready=0: pending_target <= target; state <= REDIRECT_WAIT; valid_s2 <= 0; pc holds.
REQ-026 FETCH, no redirect, imem_ready=1: instr_s2 <= imem_rdata; pc_plus4_s2 <= pc+4; pc <= pc+4; valid_s2 <= 1.
REQ-027 FETCH, no redirect, imem_ready=0: pc holds; valid_s2 <= 0.
REQ-028 REDIRECT_WAIT, ~stall: valid_s2 <= 0 every cycle. When imem_ready=1, the wrong-path data is discarded, pc <= pending_target and state <= FETCH.
REQ-029 In REDIRECT_WAIT, valid_s2=0, so no new redirect can be raised.
REQ-030 Fetch-to-stage-2 latency SHALL be one cycle. Redirect penalty SHALL be one bubble with imem_ready=1, or one plus the wait cycles otherwise.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set:
- pc = RESET_PC
- state = FETCH
- valid_s2 = 0
- instr_s2 = 0, pc_plus4_s2 = 0, pending_target = 0
REQ-032 Reset SHALL override stall, redirect and imem_ready, including in the middle of REDIRECT_WAIT.
REQ-033 redirect_s2 SHALL be 0 during and after reset until a valid stage-2 instruction exists.

Structure
REQ-034 The shared package pipe_pkg SHALL hold the fetch_state_t enum (FETCH, REDIRECT_WAIT) and the RESET_PC_DEFAULT constant.
REQ-035 Target selection and arithmetic (REQ-019/020) SHALL be in the combinational sub-module next_pc_sel; the FSM and registers stay in pc_fetch.

Verification
REQ-036 Reset, then imem_ready=1 for 3 cycles -> imem_addr 0x00400000, 0x00400004, 0x00400008; valid_s2 goes 0, 1, 1.
REQ-037 beq at pc_plus4_s2=0x00400008, equal=1, sign_ext_imm=0xFFFFFFFE -> redirect_s2=1; next imem_addr=0x00400000; valid_s2=0 for one cycle.
REQ-038 jump and branch_taken together, jump_reg=0, instr_s2[25:0]=0x0000010 -> target 0x00000040; the branch is ignored.
REQ-039 jr with jr_target=0x00400023 and imem_ready=0 for 2 cycles -> state REDIRECT_WAIT; after ready, imem_addr=0x00400020; valid_s2=0 throughout.
REQ-040 stall=1 for 3 cycles during a valid bne with not_equal=1 -> outputs frozen and redirect_s2=0; redirect fires in the first cycle with stall=0.
REQ-041 rst_n=0 during REDIRECT_WAIT -> next cycle imem_addr=RESET_PC, state FETCH, pending target never used.
